tx_frame_scheduler: RTL
=======================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 Parameter MAGIC0, default 32'h1CEB00DA, magic number prepended to frames from requester 0.
REQ-002 Parameter MAGIC1, default 32'hD0D0D0D0, magic number prepended to frames from requester 1.
REQ-003 Parameter MAGIC2, default 32'hBAADA555, magic number prepended to frames from requester 2.
REQ-004 Parameter MAX_LEN, default 24, maximum payload bytes per frame.
REQ-005 Parameter GAP_CYCLES, default 16, idle cycles between frames for RS485 bus turnaround.
REQ-006 Ports, one per line:
- CLK  in  1  system clock; all logic on rising edge; one clock only; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- req  in  3  per-requester frame request, level.
- len0, len1, len2  in  5 each  payload length of the matching requester, sampled at grant.
- byte_data0, byte_data1, byte_data2  in  8 each  payload byte at byte_addr, combinational from the requester.
- byte_addr  out  5  payload byte index; shared by all requesters.
- grant  out  3  one-hot; high for the entire frame of the owning requester.
- done  out  3  one-cycle pulse when that requester's frame has fully transmitted.
- len_err  out  3  one-cycle pulse when a request is rejected for len > MAX_LEN.
- tx_transmit  out  1  one-cycle start strobe to the uart_tx block.
- tx_data  out  8  byte for uart_tx; stable from strobe until tx_done.
- tx_done  in  1  uart_tx byte-complete pulse.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 States: IDLE, MAGIC, PAYLOAD, CRC_HI, CRC_LO, GAP.
REQ-008 Frame byte order on the wire: 4 magic bytes (MSB first), then len payload bytes (index 0 first), then CRC[15:8], then CRC[7:0].
REQ-009 CRC: polynomial x^16+x^15+x^2+1; init 16'hFFFF; data bit 7 first; no reflection; no final XOR; covers payload bytes only, not the magic.
REQ-010 Arbitration in IDLE uses round-robin among asserted req bits, starting from the index after the last granted requester. After reset, requester 0 has first priority.
REQ-011 Grant timing: grant is set one cycle after req is seen in IDLE. The winner's len is latched and the CRC is set to 16'hFFFF in that same cycle.
REQ-012 A request with latched len > MAX_LEN:
- pulses len_err for that requester;
- issues no grant and sends no bytes;
- advances the round-robin pointer;
- returns to IDLE.
REQ-013 Per-byte handshake:
- pulse tx_transmit for exactly 1 cycle with tx_data valid;
- wait for tx_done;
- on the cycle after tx_done, issue the next byte's strobe.
- There is at most one outstanding byte at any time.
REQ-014 In PAYLOAD:
- byte_addr = current payload index; tx_data captures byte_data of the granted requester at the strobe;
- the CRC updates with that same byte at the strobe;
- byte_addr increments on tx_done.
REQ-015 len = 0: the scheduler goes MAGIC -> CRC_HI directly, and the transmitted CRC is 16'hFFFF.
REQ-016 After CRC_LO completes (tx_done):
- done pulses for the granted requester;
- grant clears;
- the state enters GAP and counts GAP_CYCLES cycles, then returns to IDLE.
REQ-017 Requests are not sampled during GAP or during any frame state.
REQ-018 If req deasserts mid-frame, the frame still completes normally and done still pulses.
REQ-019 tx_done while no byte is outstanding is ignored.
REQ-020 Simultaneous requests are resolved only by REQ-010; exactly one grant bit is high at any time.
REQ-021 GAP_CYCLES = 0: the state goes GAP -> IDLE in one cycle.
REQ-022 byte_addr never exceeds len-1 while in PAYLOAD; it is 0 in every other state.

Reset
REQ-023 Reset value of every output and internal register:
- state = IDLE;
- grant = 0, done = 0, len_err = 0, tx_transmit = 0;
- tx_data = 0, byte_addr = 0, busy = 0;
- CRC = 16'hFFFF; round-robin pointer selects requester 0.
REQ-024 Reset asserted mid-frame aborts the frame on the next clock edge: tx_transmit = 0, no done pulse, and the remaining bytes are never sent.

Verification
REQ-025 req=3'b001, len0=9, payload "123456789", MAGIC0 default -> wire bytes 1C EB 00 DA 31..39 AE E7; done[0] pulses once.
REQ-026 req=3'b011 held continuously, len0=len1=1 -> frame order 0,1,0,1; a gap of at least GAP_CYCLES idle cycles separates each frame.
REQ-027 req=3'b100, len2=0 -> wire bytes BA AD A5 55 FF FF; done[2] pulses.
REQ-028 req=3'b010, len1=25 -> len_err[1] pulses; no tx_transmit; grant stays 0.
REQ-029 reset pulsed after the 3rd payload byte of a 20-byte frame -> all outputs at reset values the next cycle; a subsequent req=3'b001 is served from magic byte 0.
REQ-030 Spurious tx_done pulses injected during GAP and IDLE -> no change in state or outputs; the byte count of the following frame is exact.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler for three requesters feeding a byte-wide uart_tx.
// Frame = 4 magic bytes, payload, CRC-16 (poly 0x8005, init FFFF) over the payload.
module tx_frame_scheduler #(
    parameter logic [31:0] MAGIC0     = 32'h1CEB00DA,
    parameter logic [31:0] MAGIC1     = 32'hD0D0D0D0,
    parameter logic [31:0] MAGIC2     = 32'hBAADA555,
    parameter int          MAX_LEN    = 24,
    parameter int          GAP_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [4:0] len0,
    input  logic [4:0] len1,
    input  logic [4:0] len2,
    input  logic [7:0] byte_data0,
    input  logic [7:0] byte_data1,
    input  logic [7:0] byte_data2,
    output logic [4:0] byte_addr,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [2:0] len_err,
    output logic       tx_transmit,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        MAGIC,
        PAYLOAD,
        CRC_HI,
        CRC_LO,
        GAP
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  owner;
    logic [1:0]  win;
    logic        win_ok;
    logic [4:0]  win_len;
    logic [4:0]  len_q;
    logic [15:0] crc;
    logic        pend;
    logic [1:0]  mcnt;
    logic [31:0] gcnt;
    logic [7:0]  cur_byte;
    logic [31:0] magic;
    logic [7:0]  mbyte;
    int          idx;

    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0]  d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Scan from ptr upward; the nearest asserted request wins.
    always_comb begin
        win    = 2'd0;
        win_ok = 1'b0;
        idx    = 0;
        for (int i = 2; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= 3) idx = idx - 3;
            if (req[idx]) begin
                win    = 2'(idx);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (win)
            2'd0:    win_len = len0;
            2'd1:    win_len = len1;
            default: win_len = len2;
        endcase
    end

    always_comb begin
        unique case (owner)
            2'd0: begin
                cur_byte = byte_data0;
                magic    = MAGIC0;
            end
            2'd1: begin
                cur_byte = byte_data1;
                magic    = MAGIC1;
            end
            default: begin
                cur_byte = byte_data2;
                magic    = MAGIC2;
            end
        endcase
    end

    always_comb begin
        unique case (mcnt)
            2'd0:    mbyte = magic[31:24];
            2'd1:    mbyte = magic[23:16];
            2'd2:    mbyte = magic[15:8];
            default: mbyte = magic[7:0];
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            len_err     <= '0;
            tx_transmit <= 1'b0;
            tx_data     <= '0;
            byte_addr   <= '0;
            crc         <= 16'hFFFF;
            ptr         <= '0;
            owner       <= '0;
            len_q       <= '0;
            pend        <= 1'b0;
            mcnt        <= '0;
            gcnt        <= '0;
        end else begin
            done        <= '0;
            len_err     <= '0;
            tx_transmit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_ok) begin
                        ptr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                        owner <= win;
                        len_q <= win_len;
                        crc   <= 16'hFFFF;
                        if (int'(win_len) > MAX_LEN) begin
                            len_err <= 3'b001 << win;
                        end else begin
                            grant <= 3'b001 << win;
                            mcnt  <= '0;
                            pend  <= 1'b0;
                            state <= MAGIC;
                        end
                    end
                end
                // Each byte state: strobe when idle, advance on the matching tx_done.
                MAGIC: begin
                    if (!pend) begin
                        tx_transmit <= 1'b1;
                        tx_data     <= mbyte;
                        pend        <= 1'b1;
                    end else if (tx_done) begin
                        pend <= 1'b0;
                        mcnt <= mcnt + 2'd1;
                        if (mcnt == 2'd3)
                            state <= (len_q == '0) ? CRC_HI : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!pend) begin
                        tx_transmit <= 1'b1;
                        tx_data     <= cur_byte;
                        crc         <= crc_step(crc, cur_byte);
                        pend        <= 1'b1;
                    end else if (tx_done) begin
                        pend <= 1'b0;
                        if (byte_addr == len_q - 5'd1) begin
                            byte_addr <= '0;
                            state     <= CRC_HI;
                        end else begin
                            byte_addr <= byte_addr + 5'd1;
                        end
                    end
                end
                CRC_HI: begin
                    if (!pend) begin
                        tx_transmit <= 1'b1;
                        tx_data     <= crc[15:8];
                        pend        <= 1'b1;
                    end else if (tx_done) begin
                        pend  <= 1'b0;
                        state <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (!pend) begin
                        tx_transmit <= 1'b1;
                        tx_data     <= crc[7:0];
                        pend        <= 1'b1;
                    end else if (tx_done) begin
                        pend  <= 1'b0;
                        done  <= grant;
                        grant <= '0;
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt + 32'd1 >= 32'(GAP_CYCLES)) state <= IDLE;
                    else                                 gcnt  <= gcnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
